// File: rtl/mem_dbus_ctrl.sv
// mem_dbus_ctrl: MEM-stage data-bus master with alignment checks, lane steering, timeout and flush handling
module mem_dbus_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int EXC_W = 5
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  input  logic             flush,
  input  logic [3:0]       mem_op,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_din,
  input  logic [EXC_W-1:0] mem_exc_in,
  output logic             stallreq_mem,
  output logic [31:0]      mem_rdata,
  output logic             mem_done,
  output logic [EXC_W-1:0] mem_exc_out,
  output logic             dbus_req,
  output logic             dbus_we,
  output logic [31:0]      dbus_addr,
  output logic [3:0]       dbus_be,
  output logic [31:0]      dbus_wdata,
  input  logic             dbus_gnt,
  input  logic             dbus_rvalid,
  input  logic [31:0]      dbus_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;
  state_t state, state_n;
  logic [3:0] op_q;
  logic [31:0] addr_q, din_q, rdata_q, lane, ext;
  logic [CW-1:0] cnt;
  logic [EXC_W-1:0] exc_q;
  logic drain_q, cur_ld, cur_st, cur_b, cur_h, cur_ok, aligned, start, tmo_fire;
  logic q_st, q_b, q_h, q_u;
  assign cur_ld = mem_op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
  assign cur_st = mem_op inside {4'd9, 4'd10, 4'd11};
  assign cur_b = mem_op inside {4'd1, 4'd2, 4'd9};
  assign cur_h = mem_op inside {4'd3, 4'd4, 4'd10};
  assign cur_ok = cur_ld | cur_st;
  assign aligned = cur_b | (cur_h & ~mem_addr[0]) | (mem_addr[1:0] == 2'b00);
  assign start = cur_ok & (mem_exc_in == '0) & aligned & ~flush;
  assign q_st = op_q inside {4'd9, 4'd10, 4'd11};
  assign q_b = op_q inside {4'd1, 4'd2, 4'd9};
  assign q_h = op_q inside {4'd3, 4'd4, 4'd10};
  assign q_u = op_q inside {4'd2, 4'd4};
  assign lane = dbus_rdata >> {addr_q[1:0], 3'b000};
  assign ext = q_b ? {{24{~q_u & lane[7]}}, lane[7:0]} :
               q_h ? {{16{~q_u & lane[15]}}, lane[15:0]} : dbus_rdata;
  // State register
  always_ff @(posedge cpu_clk_50M)
    state <= cpu_rst ? IDLE : state_n;
  // Next state and control outputs; a bus response always beats the timeout in the same cycle
  always_comb begin
    state_n = state;
    tmo_fire = (cnt == CW'(TIMEOUT - 1)) & ~flush &
               (((state == REQ) & ~dbus_gnt) | ((state == WAIT) & ~dbus_rvalid));
    stallreq_mem = ((state == IDLE) & start) | (state == REQ) | (state == WAIT) | ((state == DRAIN) & cur_ok);
    mem_done = state == DONE;
    dbus_req = state == REQ;
    case (state)
      IDLE:  state_n = start ? REQ : IDLE;
      REQ:   state_n = dbus_gnt ? (flush ? (q_st ? IDLE : DRAIN) : (q_st ? DONE : WAIT)) :
                       flush ? IDLE : tmo_fire ? DONE : REQ;
      WAIT:  state_n = flush ? (dbus_rvalid ? IDLE : DRAIN) : (dbus_rvalid | tmo_fire) ? DONE : WAIT;
      DONE:  state_n = drain_q ? DRAIN : IDLE;
      DRAIN: state_n = dbus_rvalid ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  // Latch the op at start, count REQ/WAIT cycles, capture load data and the completion exception
  always_ff @(posedge cpu_clk_50M)
    if (cpu_rst) begin
      op_q <= '0;
      addr_q <= '0;
      din_q <= '0;
      rdata_q <= '0;
      exc_q <= '0;
      drain_q <= 1'b0;
      cnt <= '0;
    end else begin
      cnt <= (state == REQ || state == WAIT) ? cnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        op_q <= mem_op;
        addr_q <= mem_addr;
        din_q <= mem_din;
        rdata_q <= '0;
        exc_q <= '0;
        drain_q <= 1'b0;
      end
      if (state == WAIT && dbus_rvalid && !flush) rdata_q <= ext;
      if (tmo_fire) begin
        exc_q <= EXC_W'(7);
        drain_q <= state == WAIT;
      end
    end
  assign mem_rdata = rdata_q;
  assign mem_exc_out = (mem_exc_in != '0) ? mem_exc_in :
                       (state == DONE) ? exc_q :
                       ((state == IDLE) & cur_ok & ~aligned & ~flush) ? (cur_st ? EXC_W'(5) : EXC_W'(4)) : '0;
  assign dbus_we = dbus_req & q_st;
  assign dbus_addr = dbus_req ? {addr_q[31:2], 2'b00} : '0;
  assign dbus_be = ~dbus_req ? 4'b0000 :
                   (q_st & q_b) ? 4'b0001 << addr_q[1:0] :
                   (q_st & q_h) ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign dbus_wdata = ~dbus_we ? '0 : q_b ? {4{din_q[7:0]}} : q_h ? {2{din_q[15:0]}} : din_q;
endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// tb_mem_dbus_ctrl: vector table, directed multi-cycle corner sequences and randomized model-checked accesses
module tb_mem_dbus_ctrl;
  logic cpu_clk_50M = 1'b0;
  logic cpu_rst, flush, stallreq_mem, mem_done, dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
  logic [3:0] mem_op, dbus_be;
  logic [31:0] mem_addr, mem_din, mem_rdata, dbus_addr, dbus_wdata, dbus_rdata;
  logic [4:0] mem_exc_in, mem_exc_out;
  int checks = 0, errors = 0;
  always #10 cpu_clk_50M = ~cpu_clk_50M;
  mem_dbus_ctrl #(.TIMEOUT(64), .EXC_W(5)) dut (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst), .flush(flush), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_exc_in(mem_exc_in), .stallreq_mem(stallreq_mem),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_exc_out(mem_exc_out), .dbus_req(dbus_req),
    .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
  );
  typedef struct {
    logic [3:0] op;
    logic [31:0] addr, din, rd;
    int gd, rvd;
    logic [31:0] e_rd;
    logic [4:0] e_exc;
    logic [3:0] e_be;
    logic [31:0] e_wd;
  } vec_t;
  vec_t vecs[15];
  vec_t rv;
  logic [3:0] ops[8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11};
  int n;
  bit seen;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic nxt();
    @(posedge cpu_clk_50M);
    #1;
  endtask
  task automatic mid();
    @(negedge cpu_clk_50M);
  endtask
  // Reference: sizes, lanes and extension from plain arithmetic on the access description
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] rd, output logic [31:0] e_rd, output logic [4:0] e_exc,
                                output logic [3:0] e_be, output logic [31:0] e_wd);
    int sz, off;
    bit st, uns;
    longint mask, v;
    sz = (op == 1 || op == 2 || op == 9) ? 1 : (op == 3 || op == 4 || op == 10) ? 2 : 4;
    st = op >= 9;
    uns = op == 2 || op == 4;
    off = int'(a % 4);
    mask = (64'd1 << (8 * sz)) - 1;
    v = longint'(rd >> (8 * off)) & mask;
    if (!uns && sz < 4 && ((v >> (8 * sz - 1)) & 1) != 0) v = v | ~mask;
    e_exc = (off % sz != 0) ? (st ? 5'd5 : 5'd4) : 5'd0;
    e_be = st ? 4'(((1 << sz) - 1) << off) : 4'hF;
    e_wd = st ? 32'((longint'(d) & mask) * ((sz == 1) ? 64'h01010101 : (sz == 2) ? 64'h00010001 : 64'd1)) : 32'd0;
    e_rd = st ? 32'd0 : 32'(v);
  endfunction
  task automatic run(input vec_t v);
    logic st;
    st = v.op >= 4'd9;
    mem_op = v.op;
    mem_addr = v.addr;
    mem_din = v.din;
    mid();
    if (v.e_exc == 5'd4 || v.e_exc == 5'd5) begin
      chk("mis_stall", stallreq_mem, 0);
      chk("mis_req", dbus_req, 0);
      chk("mis_exc", mem_exc_out, v.e_exc);
    end else begin
      chk("start_stall", stallreq_mem, 1);
      nxt();
      for (int k = 0; k <= v.gd; k++) begin
        dbus_gnt = k == v.gd;
        mid();
        chk("req", dbus_req, 1);
        chk("req_stall", stallreq_mem, 1);
        chk("req_we", dbus_we, st);
        chk("req_addr", dbus_addr, {v.addr[31:2], 2'b00});
        chk("req_be", dbus_be, v.e_be);
        if (st) chk("req_wdata", dbus_wdata, v.e_wd);
        nxt();
      end
      dbus_gnt = 0;
      if (!st) for (int k = 0; k <= v.rvd; k++) begin
        dbus_rvalid = k == v.rvd;
        dbus_rdata = (k == v.rvd) ? v.rd : $urandom;
        mid();
        chk("wait_stall", stallreq_mem, 1);
        chk("wait_done", mem_done, 0);
        nxt();
      end
      dbus_rvalid = 0;
      mid();
      chk("done", mem_done, 1);
      chk("done_stall", stallreq_mem, 0);
      chk("done_exc", mem_exc_out, v.e_exc);
      if (!st) chk("done_rdata", mem_rdata, v.e_rd);
    end
    nxt();
    mem_op = 0;
  endtask
  task automatic lw(input logic [31:0] a, input logic [31:0] rd);
    vec_t v;
    v = '{4'd5, a, 32'd0, rd, 0, 1, rd, 5'd0, 4'hF, 32'd0};
    run(v);
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0]  = '{4'd5,  32'h1000, 32'h0,        32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 5'd0, 4'hF, 32'h0};
    vecs[1]  = '{4'd1,  32'h1003, 32'h0,        32'h80FF1234, 0, 0, 32'hFFFFFF80, 5'd0, 4'hF, 32'h0};
    vecs[2]  = '{4'd2,  32'h1003, 32'h0,        32'h80FF1234, 0, 0, 32'h00000080, 5'd0, 4'hF, 32'h0};
    vecs[3]  = '{4'd10, 32'h2002, 32'h0000ABCD, 32'h0,        0, 0, 32'h0,        5'd0, 4'hC, 32'hABCDABCD};
    vecs[4]  = '{4'd5,  32'h1002, 32'h0,        32'h0,        0, 0, 32'h0,        5'd4, 4'h0, 32'h0};
    vecs[5]  = '{4'd11, 32'h1001, 32'h0,        32'h0,        0, 0, 32'h0,        5'd5, 4'h0, 32'h0};
    vecs[6]  = '{4'd3,  32'h2002, 32'h0,        32'h80017FFF, 1, 0, 32'hFFFF8001, 5'd0, 4'hF, 32'h0};
    vecs[7]  = '{4'd4,  32'h2000, 32'h0,        32'h1234F00D, 0, 1, 32'h0000F00D, 5'd0, 4'hF, 32'h0};
    vecs[8]  = '{4'd9,  32'h3001, 32'h1234565A, 32'h0,        2, 0, 32'h0,        5'd0, 4'h2, 32'h5A5A5A5A};
    vecs[9]  = '{4'd11, 32'h3004, 32'h12345678, 32'h0,        1, 0, 32'h0,        5'd0, 4'hF, 32'h12345678};
    vecs[10] = '{4'd3,  32'h1001, 32'h0,        32'h0,        0, 0, 32'h0,        5'd4, 4'h0, 32'h0};
    vecs[11] = '{4'd10, 32'h1003, 32'h0,        32'h0,        0, 0, 32'h0,        5'd5, 4'h0, 32'h0};
    vecs[12] = '{4'd1,  32'h1001, 32'h0,        32'h00007F00, 1, 2, 32'h0000007F, 5'd0, 4'hF, 32'h0};
    vecs[13] = '{4'd3,  32'h2000, 32'h0,        32'h00008000, 0, 1, 32'hFFFF8000, 5'd0, 4'hF, 32'h0};
    vecs[14] = '{4'd9,  32'h3003, 32'h000000C3, 32'h0,        0, 0, 32'h0,        5'd0, 4'h8, 32'hC3C3C3C3};
    cpu_rst = 1; flush = 0; mem_op = 0; mem_addr = 0; mem_din = 0; mem_exc_in = 0;
    dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 0;
    repeat (3) nxt();
    mid();
    chk("rst_stall", stallreq_mem, 0);
    chk("rst_done", mem_done, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_exc", mem_exc_out, 0);
    chk("rst_req", dbus_req, 0);
    chk("rst_we", dbus_we, 0);
    chk("rst_addr", dbus_addr, 0);
    chk("rst_be", dbus_be, 0);
    chk("rst_wdata", dbus_wdata, 0);
    nxt();
    cpu_rst = 0;
    foreach (vecs[i]) run(vecs[i]);
    // Unknown opcode behaves as NONE
    mem_op = 4'd6; mem_addr = 32'h1001;
    mid(); chk("none_stall", stallreq_mem, 0); chk("none_exc", mem_exc_out, 0); nxt();
    mid(); chk("none_req", dbus_req, 0); nxt();
    // Upstream exception suppresses the access and passes through
    mem_op = 4'd5; mem_addr = 32'h1000; mem_exc_in = 5'd3;
    mid(); chk("upexc_stall", stallreq_mem, 0); chk("upexc_exc", mem_exc_out, 3); nxt();
    mid(); chk("upexc_req", dbus_req, 0); nxt();
    mem_exc_in = 0; mem_op = 0;
    // Grant never arrives: bus error after TIMEOUT request cycles
    mem_op = 4'd5; mem_addr = 32'h4000;
    mid(); nxt();
    n = 0; seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      mid();
      if (mem_done) begin
        seen = 1;
        chk("tmo_exc", mem_exc_out, 7);
        chk("tmo_rdata", mem_rdata, 0);
        chk("tmo_stall", stallreq_mem, 0);
      end else n += int'(dbus_req);
      nxt();
    end
    mem_op = 0;
    chk("tmo_seen", seen, 1);
    chk("tmo_req_cycles", n, 64);
    // Timeout while waiting for data: the late response is drained before the next access
    mem_op = 4'd5; mem_addr = 32'h4100;
    mid(); nxt();
    dbus_gnt = 1; mid(); nxt(); dbus_gnt = 0;
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      mid();
      if (mem_done) begin
        seen = 1;
        chk("wtmo_exc", mem_exc_out, 7);
        chk("wtmo_rdata", mem_rdata, 0);
      end
      nxt();
    end
    chk("wtmo_seen", seen, 1);
    mem_addr = 32'h4200;
    mid(); chk("wdrain_stall", stallreq_mem, 1); chk("wdrain_req", dbus_req, 0); nxt();
    mid(); chk("wdrain_req2", dbus_req, 0); nxt();
    dbus_rvalid = 1; dbus_rdata = $urandom;
    mid(); chk("wdrain_done", mem_done, 0); nxt();
    dbus_rvalid = 0;
    lw(32'h4200, 32'hCAFEF00D);
    // Flush in WAIT, response three cycles later, next load queued behind DRAIN
    mem_op = 4'd5; mem_addr = 32'h1000;
    mid(); nxt();
    dbus_gnt = 1; mid(); nxt(); dbus_gnt = 0;
    flush = 1; mid(); chk("fw_done", mem_done, 0); nxt();
    flush = 0; mem_addr = 32'h1100;
    mid(); chk("fw_stall", stallreq_mem, 1); chk("fw_req", dbus_req, 0); chk("fw_done2", mem_done, 0); nxt();
    mid(); chk("fw_req2", dbus_req, 0); nxt();
    dbus_rvalid = 1; dbus_rdata = $urandom;
    mid(); chk("fw_done3", mem_done, 0); chk("fw_req3", dbus_req, 0); nxt();
    dbus_rvalid = 0;
    lw(32'h1100, 32'h11223344);
    // Flush in REQ without grant drops the request
    mem_op = 4'd5; mem_addr = 32'h1200;
    mid(); nxt();
    flush = 1; mid(); chk("fr_req", dbus_req, 1); nxt();
    flush = 0; mem_op = 0;
    mid(); chk("fr_req2", dbus_req, 0); chk("fr_done", mem_done, 0); chk("fr_stall", stallreq_mem, 0); nxt();
    // Flush with grant on a store: write committed, straight back to IDLE
    mem_op = 4'd11; mem_addr = 32'h1300; mem_din = 32'h0BADF00D;
    mid(); nxt();
    dbus_gnt = 1; flush = 1; mid(); chk("fs_we", dbus_we, 1); nxt();
    dbus_gnt = 0; flush = 0; mem_op = 0;
    mid(); chk("fs_done", mem_done, 0); chk("fs_req", dbus_req, 0); nxt();
    lw(32'h1304, 32'h55667788);
    // Flush with grant on a load: response must be drained
    mem_op = 4'd5; mem_addr = 32'h1400;
    mid(); nxt();
    dbus_gnt = 1; flush = 1; mid(); nxt();
    dbus_gnt = 0; flush = 0; mem_op = 0;
    mid(); chk("fl_done", mem_done, 0); chk("fl_stall", stallreq_mem, 0); nxt();
    mem_op = 4'd5; mem_addr = 32'h1404;
    mid(); chk("fl_stall2", stallreq_mem, 1); chk("fl_req", dbus_req, 0); nxt();
    dbus_rvalid = 1; dbus_rdata = $urandom; mid(); nxt(); dbus_rvalid = 0;
    lw(32'h1404, 32'h99AABBCC);
    // Flush and rvalid together in WAIT: data discarded, IDLE next
    mem_op = 4'd5; mem_addr = 32'h1500;
    mid(); nxt();
    dbus_gnt = 1; mid(); nxt(); dbus_gnt = 0;
    flush = 1; dbus_rvalid = 1; dbus_rdata = 32'h13572468;
    mid(); chk("frv_done", mem_done, 0); nxt();
    flush = 0; dbus_rvalid = 0;
    lw(32'h1508, 32'h24681357);
    // Reset in the middle of a load
    mem_op = 4'd5; mem_addr = 32'h1600;
    mid(); nxt();
    dbus_gnt = 1; mid(); nxt(); dbus_gnt = 0;
    cpu_rst = 1; nxt(); cpu_rst = 0; mem_op = 0;
    mid(); chk("mrst_req", dbus_req, 0); chk("mrst_stall", stallreq_mem, 0); chk("mrst_done", mem_done, 0); nxt();
    lw(32'h1604, 32'h0F0F0F0F);
    // Randomized accesses against the reference model
    for (int i = 0; i < 150; i++) begin
      rv.op = ops[$urandom_range(0, 7)];
      rv.addr = $urandom;
      if ($urandom_range(0, 4) != 0)
        rv.addr[1:0] = (rv.op == 5 || rv.op == 11) ? 2'b00 :
                       (rv.op == 3 || rv.op == 4 || rv.op == 10) ? {rv.addr[1], 1'b0} : rv.addr[1:0];
      rv.din = $urandom;
      rv.rd = $urandom;
      rv.gd = $urandom_range(0, 3);
      rv.rvd = $urandom_range(0, 3);
      model(rv.op, rv.addr, rv.din, rv.rd, rv.e_rd, rv.e_exc, rv.e_be, rv.e_wd);
      run(rv);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
